// File: rtl/if_pc_stage.sv
// Instruction-fetch PC register and IF/ID pipeline register with hazard-driven
// hold/redirect control and saturating stall/flush event counters.
module if_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0]      r_pc;
    logic [31:0]      r_if_id_pc;
    logic [31:0]      r_if_id_instr;
    logic             r_if_id_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_hold;
    logic             w_redirect;
    logic [31:0]      w_pc_plus4;
    logic             w_stall_sat;
    logic             w_flush_sat;

    // Stall has priority: a flush arriving during a stall is dropped and
    // re-presented by the hazard unit once the stall clears.
    assign w_hold      = stall_i;
    assign w_redirect  = flush_i && !stall_i;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_stall_sat = &r_stall_cnt;
    assign w_flush_sat = &r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_if_id_pc    <= 32'h0;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else if (w_hold) begin
            if (!w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end else if (w_redirect) begin
            r_pc          <= {branch_target_i[31:2], 2'b00};
            r_if_id_pc    <= 32'h0;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
            if (!w_flush_sat) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end else begin
            r_pc          <= w_pc_plus4;
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= instr_i;
            r_if_id_valid <= 1'b1;
        end
    end

    assign pc_o          = r_pc;
    assign if_id_pc_o    = r_if_id_pc;
    assign if_id_instr_o = r_if_id_instr;
    assign if_id_valid_o = r_if_id_valid;
    assign bubble_o      = stall_i;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule
